// File: rtl/fuzz_seq_pkg.sv
// fuzz_seq_pkg: sequencer state encoding, default widths and the MISR step
// function shared by the design and its bench.
package fuzz_seq_pkg;

    localparam int VEC_W = 86;
    localparam int OUT_W = 81;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } state_e;

    function automatic logic [OUT_W-1:0] misr_step(
        input logic [OUT_W-1:0] sig,
        input logic [OUT_W-1:0] data,
        input logic [OUT_W-1:0] poly
    );
        return {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? poly : {OUT_W{1'b0}}) ^ data;
    endfunction

endpackage

// File: rtl/fuzz_vector_sequencer_misr.sv
// fuzz_misr: multiple-input signature register with seed-load and step enables.
module fuzz_misr #(
    parameter int               OUT_W     = 81,
    parameter logic [OUT_W-1:0] MISR_POLY = 81'h201,
    parameter logic [OUT_W-1:0] MISR_SEED = 81'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_seed_load,
    input  logic             i_step,
    input  logic [OUT_W-1:0] i_data,
    output logic [OUT_W-1:0] o_signature
);

    logic [OUT_W-1:0] r_sig;
    logic [OUT_W-1:0] w_sig_step;

    // Shift left, fold the outgoing MSB back through the taps, absorb the sample.
    always_comb begin
        w_sig_step = {r_sig[OUT_W-2:0], 1'b0}
                   ^ (r_sig[OUT_W-1] ? MISR_POLY : {OUT_W{1'b0}})
                   ^ i_data;
    end

    // Signature register; seed load wins over a step in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= MISR_SEED;
        end else if (i_seed_load) begin
            r_sig <= MISR_SEED;
        end else if (i_step) begin
            r_sig <= w_sig_step;
        end else begin
            r_sig <= r_sig;
        end
    end

    assign o_signature = r_sig;

endmodule

// File: rtl/fuzz_vector_sequencer.sv
// fuzz_vector_sequencer: drives stream vectors onto a DUT bus, waits a settle
// time and folds the DUT response into a MISR. Option: FUZZ_SEQ_CAPTURE_EN.
module fuzz_vector_sequencer #(
    parameter int                  VEC_W      = fuzz_seq_pkg::VEC_W,
    parameter int                  OUT_W      = fuzz_seq_pkg::OUT_W,
    parameter int                  CNT_W      = fuzz_seq_pkg::CNT_W,
    parameter int                  SETTLE_CYC = 1,
    parameter logic [OUT_W-1:0]    MISR_POLY  = 81'h201,
    parameter logic [OUT_W-1:0]    MISR_SEED  = 81'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             vec_valid,
    input  logic [VEC_W-1:0] vec_data,
    output logic             vec_ready,
    output logic [VEC_W-1:0] dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [OUT_W-1:0] signature
`ifdef FUZZ_SEQ_CAPTURE_EN
    ,
    output logic             cap_valid,
    output logic [OUT_W-1:0] cap_data,
    input  logic             cap_ready
`endif
);

    import fuzz_seq_pkg::*;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [31:0]      r_settle_cnt;
    logic [CNT_W-1:0] r_num_vec;
    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [VEC_W-1:0] r_dut_in;
    logic             r_vec_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_start_acc;
    logic             w_hs;
    logic             w_capture;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_hs        = (r_state == LOAD) && vec_valid && r_vec_ready;
    assign w_capture   = (r_state == CAPTURE);
    assign w_cnt_inc   = r_vec_count + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef FUZZ_SEQ_CAPTURE_EN
    logic             r_cap_valid;
    logic [OUT_W-1:0] r_cap_data;
    logic             w_cap_hs;

    assign w_cap_hs  = (r_state == EMIT) && r_cap_valid && cap_ready;
    assign cap_valid = r_cap_valid;
    assign cap_data  = r_cap_data;
`endif

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (num_vec == {CNT_W{1'b0}}) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (w_hs) begin
                    w_state_nxt = SETTLE;
                end else begin
                    w_state_nxt = LOAD;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == 32'(SETTLE_CYC - 1)) begin
                    w_state_nxt = CAPTURE;
                end else begin
                    w_state_nxt = SETTLE;
                end
            end
`ifdef FUZZ_SEQ_CAPTURE_EN
            CAPTURE: w_state_nxt = EMIT;
            EMIT: begin
                if (w_cap_hs) begin
                    if (r_vec_count == r_num_vec) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end else begin
                    w_state_nxt = EMIT;
                end
            end
`else
            CAPTURE: begin
                // vec_count advances on this same edge, so compare its next value.
                if (w_cnt_inc == r_num_vec) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = LOAD;
                end
            end
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vec_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vec_ready <= (w_state_nxt == LOAD);
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    // Run bookkeeping: latched run length, captured-vector count, settle timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_vec    <= {CNT_W{1'b0}};
            r_vec_count  <= {CNT_W{1'b0}};
            r_settle_cnt <= 32'd0;
        end else begin
            if (w_start_acc) begin
                r_num_vec   <= num_vec;
                r_vec_count <= {CNT_W{1'b0}};
            end else if (w_capture) begin
                r_vec_count <= w_cnt_inc;
            end
            r_settle_cnt <= (r_state == SETTLE) ? (r_settle_cnt + 32'd1) : 32'd0;
        end
    end

    // DUT input bus: loads on the stream handshake and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dut_in <= {VEC_W{1'b0}};
        end else if (w_hs) begin
            r_dut_in <= vec_data;
        end
    end

`ifdef FUZZ_SEQ_CAPTURE_EN
    // Capture port: sample latched in CAPTURE, valid only while in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_valid <= 1'b0;
            r_cap_data  <= {OUT_W{1'b0}};
        end else begin
            r_cap_valid <= (w_state_nxt == EMIT);
            if (w_capture) begin
                r_cap_data <= dut_out;
            end
        end
    end
`endif

    fuzz_misr #(
        .OUT_W     (OUT_W),
        .MISR_POLY (MISR_POLY),
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_seed_load (w_start_acc),
        .i_step      (w_capture),
        .i_data      (dut_out),
        .o_signature (signature)
    );

    assign vec_ready = r_vec_ready;
    assign dut_in    = r_dut_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign vec_count = r_vec_count;

endmodule

// File: doc/fuzz_vector_sequencer.md
# fuzz_vector_sequencer

Sequences directed stimulus into a fuzz-generated design under test (DUT) and checks its response. It accepts packed input vectors on a valid/ready stream and drives them onto the DUT input bus. After a programmable settle time it samples the DUT output bus and folds each sample into a MISR signature. It replaces free-running, time-delay stimulus in the fuzz simulation flow, so that synthesized and reference netlists can be compared by signature and vector count.

## Interface
Parameters:
- VEC_W, 86, packed DUT input width ({wire4, wire3, wire2, wire1, wire0}).
- OUT_W, 81, DUT output width (y).
- CNT_W, 16, vector counter width.
- SETTLE_CYC, 1, cycles between driving a vector and sampling y; legal range ≥1.
- MISR_POLY, 81'h201, MISR feedback taps.
- MISR_SEED, 81'h0, signature value after reset and at each start.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, reset; asynchronous assert, active-low.
- start, in, 1, begin a run; sampled only in IDLE.
- num_vec, in, CNT_W, vectors in the run; latched when start is accepted.
- vec_valid, in, 1, stimulus vector available.
- vec_data, in, VEC_W, stimulus vector.
- vec_ready, out, 1, high only in LOAD.
- dut_in, out, VEC_W, registered DUT input bus.
- dut_out, in, OUT_W, DUT output bus.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse in DONE.
- vec_count, out, CNT_W, vectors captured in the current or last run.
- signature, out, OUT_W, MISR state.
- cap_valid / cap_data[OUT_W] / cap_ready, out/out/in, present only with FUZZ_SEQ_CAPTURE_EN.

## Operation
States and transitions:
- IDLE → DONE on start when num_vec==0.
- IDLE → LOAD on start otherwise.
- LOAD → SETTLE on vec_valid&&vec_ready.
- SETTLE → CAPTURE after SETTLE_CYC cycles.
- CAPTURE → EMIT when FUZZ_SEQ_CAPTURE_EN is defined; otherwise CAPTURE → LOAD/DONE.
- EMIT → LOAD/DONE on cap_ready.
- The LOAD/DONE choice: DONE when vec_count==latched num_vec, else LOAD.
- DONE → IDLE unconditionally.

On start acceptance:
- signature←MISR_SEED, vec_count←0, num_vec latched.
- start while busy is ignored.

LOAD:
- vec_ready=1; stalls indefinitely while vec_valid is low.
- On handshake dut_in←vec_data.
- dut_in holds its value through the end of the run and in IDLE.

CAPTURE (one cycle):
- signature←{signature[OUT_W-2:0],1'b0} ^ (signature[OUT_W-1] ? MISR_POLY : 0) ^ dut_out.
- vec_count←vec_count+1.
- vec_count wraps modulo 2^CNT_W; the number of vectors per run is bounded by num_vec ≤ 2^CNT_W−1.

signature and vec_count persist after DONE until the next accepted start.

Reset values:
- state IDLE; dut_in 0; vec_ready 0; busy 0; done 0; vec_count 0; signature MISR_SEED; cap_valid 0; cap_data 0.

Reset mid-run: the run is abandoned with no done pulse, and every register returns to its reset value.

## Timing
Per vector:
- Handshake in cycle t; dut_in carries the new vector from t+1.
- SETTLE occupies t+1 … t+SETTLE_CYC.
- CAPTURE at t+SETTLE_CYC+1 samples dut_out.
- Earliest next handshake: t+SETTLE_CYC+2 without capture, t+SETTLE_CYC+3 with capture.
- Throughput without capture: one vector per SETTLE_CYC+2 cycles.

done:
- High the cycle after the last CAPTURE (or the last EMIT handshake).
- For num_vec==0: high the cycle after start.

dut_out must be a combinational function of dut_in. For registered DUTs, SETTLE_CYC must cover the pipeline depth.

## Configuration
- FUZZ_SEQ_CAPTURE_EN defined:
  - Adds the cap_* ports and the EMIT state.
  - cap_data←dut_out in CAPTURE; cap_valid high in EMIT.
  - cap_data is held stable until cap_ready; cap_valid drops the cycle after the handshake.
  - The next vec_ready is withheld until that handshake.
- Undefined: no cap_* ports, no EMIT state; CAPTURE proceeds directly to LOAD/DONE.

## Structure
- fuzz_seq_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, CAPTURE, EMIT, DONE);
  - default width constants VEC_W, OUT_W, CNT_W;
  - the misr_step function, shared with the bench scoreboard.
- One sub-module, fuzz_misr: signature register with seed-load and step enables.

## Test plan
- Reset: hold rst_n=0 → all outputs at their reset values, signature=0, busy=0.
- num_vec=0 start → busy for one cycle; done pulses the cycle after start; vec_count=0.
- Single vector, loopback model dut_out=dut_in[80:0], SETTLE_CYC=2, vec_data=86'h2A_5555_5555_5555_5555_5555 → capture 3 cycles after handshake; signature=81'h0_5555_5555_5555_5555_5555 (low 81 bits of the vector); vec_count=1; done.
- Three vectors with vec_valid low for 4 cycles between vectors → vec_ready held, no state change while stalled; final signature equals three misr_step applications; vec_count=3.
- FUZZ_SEQ_CAPTURE_EN, cap_ready low 3 cycles → cap_data stable, vec_ready low until the cap handshake, then resumes.
- rst_n pulsed low during SETTLE of vector 2 of 4 → immediate IDLE, dut_in=0, vec_count=0, no done; a new start runs 4 vectors correctly.
